// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one MIPS R/I-type ALU instruction, reads
// operands from the register file, drives the ALU and returns the result.
module alu_issue_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int OPRN_WIDTH     = 6,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [31:0]               i_instr,
   input  logic                      i_instr_valid,
   output logic                      o_instr_ready,
   output logic                      o_rf_read,
   output logic [REG_ADDR_WIDTH-1:0] o_rf_addr_r1,
   output logic [REG_ADDR_WIDTH-1:0] o_rf_addr_r2,
   input  logic [DATA_WIDTH-1:0]     i_rf_data_r1,
   input  logic [DATA_WIDTH-1:0]     i_rf_data_r2,
   output logic [DATA_WIDTH-1:0]     o_alu_op1,
   output logic [DATA_WIDTH-1:0]     o_alu_op2,
   output logic [OPRN_WIDTH-1:0]     o_alu_oprn,
   input  logic [DATA_WIDTH-1:0]     i_alu_out,
   input  logic                      i_alu_zero,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic [DATA_WIDTH-1:0]     o_res_data,
   output logic                      o_res_zero,
   output logic [REG_ADDR_WIDTH-1:0] o_res_addr,
   output logic                      o_res_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_READ, S_EXEC, S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [31:0]               r_instr;
   logic [DATA_WIDTH-1:0]     r_op1;
   logic [DATA_WIDTH-1:0]     r_op2;
   logic [OPRN_WIDTH-1:0]     r_oprn;
   logic [DATA_WIDTH-1:0]     r_res_data;
   logic                      r_res_zero;
   logic [REG_ADDR_WIDTH-1:0] r_res_addr;
   logic                      r_res_err;

   logic [5:0]                w_opc;
   logic [5:0]                w_funct;
   logic [REG_ADDR_WIDTH-1:0] w_rs;
   logic [REG_ADDR_WIDTH-1:0] w_rt;
   logic [REG_ADDR_WIDTH-1:0] w_rd;
   logic [4:0]                w_shamt;
   logic [15:0]               w_imm;
   logic [DATA_WIDTH-1:0]     w_sext;
   logic [DATA_WIDTH-1:0]     w_zext;
   logic                      w_ok;
   logic                      w_rtype;
   logic                      w_shift;
   logic                      w_zimm;
   logic                      w_lui;
   logic [OPRN_WIDTH-1:0]     w_oprn;
   logic [DATA_WIDTH-1:0]     w_op1;
   logic [DATA_WIDTH-1:0]     w_op2;

   assign w_opc   = r_instr[31:26];
   assign w_rs    = r_instr[25:21];
   assign w_rt    = r_instr[20:16];
   assign w_rd    = r_instr[15:11];
   assign w_shamt = r_instr[10:6];
   assign w_funct = r_instr[5:0];
   assign w_imm   = r_instr[15:0];
   assign w_sext  = {{(DATA_WIDTH-16){w_imm[15]}}, w_imm};
   assign w_zext  = {{(DATA_WIDTH-16){1'b0}}, w_imm};

   // Decode the latched instruction into op code and operand selects
   always_comb begin
      w_ok    = 1'b0;
      w_rtype = 1'b0;
      w_shift = 1'b0;
      w_zimm  = 1'b0;
      w_lui   = 1'b0;
      w_oprn  = '0;
      case (w_opc)
         6'h00: begin
            w_rtype = 1'b1;
            case (w_funct)
               6'h20, 6'h22, 6'h2c, 6'h24,
               6'h25, 6'h27, 6'h2a: begin
                  w_ok   = 1'b1;
                  w_oprn = OPRN_WIDTH'(w_funct);
               end
               6'h00: begin
                  w_ok    = 1'b1;
                  w_shift = 1'b1;
                  w_oprn  = OPRN_WIDTH'(6'h01);
               end
               6'h02: begin
                  w_ok    = 1'b1;
                  w_shift = 1'b1;
                  w_oprn  = OPRN_WIDTH'(6'h02);
               end
               default: ;
            endcase
         end
         6'h08: begin w_ok = 1'b1; w_oprn = OPRN_WIDTH'(6'h20); end
         6'h1d: begin w_ok = 1'b1; w_oprn = OPRN_WIDTH'(6'h2c); end
         6'h0a: begin w_ok = 1'b1; w_oprn = OPRN_WIDTH'(6'h2a); end
         6'h0c: begin
            w_ok = 1'b1; w_zimm = 1'b1; w_oprn = OPRN_WIDTH'(6'h24);
         end
         6'h0d: begin
            w_ok = 1'b1; w_zimm = 1'b1; w_oprn = OPRN_WIDTH'(6'h25);
         end
         6'h0f: begin
            w_ok = 1'b1; w_lui = 1'b1; w_oprn = OPRN_WIDTH'(6'h01);
         end
         default: ;
      endcase
   end

   // Select ALU operands from read data or the immediate fields
   always_comb begin
      w_op1 = i_rf_data_r1;
      w_op2 = w_sext;
      if (w_shift) begin
         w_op1 = i_rf_data_r2;
         w_op2 = {{(DATA_WIDTH-5){1'b0}}, w_shamt};
      end else if (w_lui) begin
         w_op1 = w_zext;
         w_op2 = DATA_WIDTH'(16);
      end else if (w_rtype) begin
         w_op2 = i_rf_data_r2;
      end else if (w_zimm) begin
         w_op2 = w_zext;
      end
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_instr_valid) w_next = S_DECODE;
         S_DECODE: w_next = w_ok ? S_READ : S_DONE;
         S_READ:   w_next = S_EXEC;
         S_EXEC:   w_next = S_DONE;
         S_DONE:   if (i_res_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // FSM outputs; the read strobe is dropped while reset is asserted
   always_comb begin
      o_instr_ready = (r_state == S_IDLE) && !i_rst;
      o_rf_read     = (r_state == S_DECODE) && w_ok && !i_rst;
      o_rf_addr_r1  = o_rf_read ? w_rs : '0;
      o_rf_addr_r2  = o_rf_read ? w_rt : '0;
      o_res_valid   = (r_state == S_DONE);
   end

   // Instruction latch, operand issue and result capture
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_instr    <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_oprn     <= '0;
         r_res_data <= '0;
         r_res_zero <= 1'b0;
         r_res_addr <= '0;
         r_res_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_instr_valid) r_instr <= i_instr;
            S_DECODE: if (!w_ok) begin
               r_res_data <= '0;
               r_res_zero <= 1'b0;
               r_res_addr <= '0;
               r_res_err  <= 1'b1;
            end
            S_READ: begin
               r_op1  <= w_op1;
               r_op2  <= w_op2;
               r_oprn <= w_oprn;
            end
            S_EXEC: begin
               r_res_data <= i_alu_out;
               r_res_zero <= i_alu_zero;
               r_res_addr <= w_rtype ? w_rd : w_rt;
               r_res_err  <= 1'b0;
            end
            S_DONE: if (i_res_ready) begin
               r_op1  <= '0;
               r_op2  <= '0;
               r_oprn <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_alu_op1  = r_op1;
   assign o_alu_op2  = r_op2;
   assign o_alu_oprn = r_oprn;
   assign o_res_data = r_res_data;
   assign o_res_zero = r_res_zero;
   assign o_res_addr = r_res_addr;
   assign o_res_err  = r_res_err;

endmodule
